// File: rtl/alu_pkg.sv
// Shared ALU command types: opcode encoding, command layout and packed-width helper.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int OP_WIDTH  = 2;

  typedef enum logic [OP_WIDTH-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    alu_op_e              op;
  } alu_cmd_t;

  // Packed bit count of one command for a given operand width.
  function automatic int cmd_bits(input int width);
    return 2 * width + OP_WIDTH;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command storage ring buffer; head is read combinationally, push/pop take effect on the clock edge.
// A push while full is dropped even if a pop happens in the same cycle; a pop while empty is ignored.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Queues ALU commands, presents the oldest to an external ALU and registers its result.
// Result valid one cycle after acceptance; output holds while out_ready is low, in_ready drops when full.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [1:0]                 in_opcode,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [1:0]                 alu_opcode,
  input  logic [WIDTH-1:0]           alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [1:0]                 out_opcode,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CMD_W = cmd_bits(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_e          op;
  } cmd_t;

  cmd_t             wr_cmd;
  cmd_t             head;
  logic [CMD_W-1:0] rd_bits;
  logic             full;
  logic             empty;
  logic             push;
  logic             fire;

  assign wr_cmd   = '{a: in_a, b: in_b, op: alu_op_e'(in_opcode)};
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign fire     = !empty && (!out_valid || out_ready);

  // Stale storage must not leak to the ALU when nothing is queued.
  assign head       = empty ? '0 : cmd_t'(rd_bits);
  assign alu_a      = head.a;
  assign alu_b      = head.b;
  assign alu_opcode = head.op;

  alu_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (fire),
    .wdata(wr_cmd),
    .rdata(rd_bits),
    .full (full),
    .empty(empty),
    .count(count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_opcode <= '0;
    end else if (fire) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_opcode <= head.op;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue with a behavioural ALU; queue-based reference model plus directed scenarios.
module tb_alu_cmd_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_opcode;
  logic [2:0]       count;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } mcmd_t;

  mcmd_t      mq[$];
  logic       mvalid;
  logic [7:0] mres;
  logic [1:0] mop;
  bit         m_fire;
  bit         m_push;
  logic [7:0] got_q[$];
  int         got_cyc[$];

  alu_cmd_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_opcode(out_opcode),
    .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ALU the queue drives.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = alu_a - alu_b;
      2'b10: alu_result = alu_a & alu_b;
      2'b11: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int r;
    case (op)
      2'b00:   r = int'($signed(a)) + int'($signed(b));
      2'b01:   r = int'($signed(a)) - int'($signed(b));
      2'b10:   r = int'({24'd0, a & b});
      default: r = int'({24'd0, a | b});
    endcase
    return 8'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced once per cycle at the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      mvalid = 1'b0;
      mres   = '0;
      mop    = '0;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'd0);
    end else begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mvalid));
      if (mvalid) begin
        chk("out_result", 32'(out_result), 32'(mres));
        chk("out_opcode", 32'(out_opcode), 32'(mop));
      end
      if (mq.size() > 0) begin
        chk("alu_a", 32'(alu_a), 32'(mq[0].a));
        chk("alu_b", 32'(alu_b), 32'(mq[0].b));
        chk("alu_opcode", 32'(alu_opcode), 32'(mq[0].op));
      end else begin
        chk("alu_idle", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_result);
        got_cyc.push_back(cyc);
      end
      m_fire = (mq.size() > 0) && (!mvalid || out_ready);
      m_push = in_valid && (mq.size() != DEPTH);
      if (m_fire) begin
        mres   = ref_alu(mq[0].a, mq[0].b, mq[0].op);
        mop    = mq[0].op;
        mvalid = 1'b1;
        void'(mq.pop_front());
      end else if (mvalid && out_ready) begin
        mvalid = 1'b0;
      end
      if (m_push) mq.push_back('{in_a, in_b, in_opcode});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bit acc;
    int guard;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    acc       = 1'b0;
    guard     = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] got_at(input int k);
    return (k < got_q.size()) ? got_q[k] : 8'hXX;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_l[$];
    logic [7:0] ra, rb;
    logic [1:0] rop;

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; out_ready = 1'b0;
    repeat (2) step();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    step();

    // Single add: result one cycle after acceptance.
    out_ready = 1'b1;
    send(8'd10, 8'd20, 2'b00);
    idle();
    chk("t1_ov_before", 32'(out_valid), 32'd0);
    step();
    chk("t1_ov", 32'(out_valid), 32'd1);
    chk("t1_result", 32'(out_result), 32'd30);
    chk("t1_opcode", 32'(out_opcode), 32'd0);
    chk("t1_count", 32'(count), 32'd0);
    step();

    // sub/AND/OR back-to-back.
    got_q.delete(); got_cyc.delete();
    send(8'd10, 8'd20, 2'b01);
    send(8'd10, 8'd20, 2'b10);
    send(8'd10, 8'd20, 2'b11);
    idle();
    repeat (5) step();
    chk("t2_n", 32'(got_q.size()), 32'd3);
    chk("t2_sub", 32'(got_at(0)), 32'(8'hF6));
    chk("t2_and", 32'(got_at(1)), 32'd0);
    chk("t2_or", 32'(got_at(2)), 32'd30);
    if (got_cyc.size() == 3) begin
      chk("t2_consec0", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
      chk("t2_consec1", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
    end

    // Fill with consumer stalled; sixth command must be refused.
    out_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 5; i++) send(8'(10 * i), 8'd1, 2'b00);
    in_a = 8'd99; in_b = 8'd99; in_opcode = 2'b00;
    repeat (3) step();
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_ov", 32'(out_valid), 32'd1);
    chk("t3_held", 32'(out_result), 32'd1);
    idle();
    out_ready = 1'b1;
    repeat (8) step();
    chk("t3_n", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t3_order", 32'(got_at(i)), 32'(10 * i + 1));

    // Simultaneous push/pop at count 2, then 3*DEPTH commands for wrap.
    out_ready = 1'b0;
    got_q.delete(); exp_l.delete();
    for (int i = 0; i < 3; i++) begin
      send(8'(i + 3), 8'(2 * i), 2'(i));
      exp_l.push_back(ref_alu(8'(i + 3), 8'(2 * i), 2'(i)));
    end
    chk("t4_count_pre", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom);
      send(ra, rb, rop);
      exp_l.push_back(ref_alu(ra, rb, rop));
      chk("t4_count_steady", 32'(count), 32'd2);
    end
    idle();
    repeat (6) step();
    chk("t4_n", 32'(got_q.size()), 32'(exp_l.size()));
    for (int i = 0; i < exp_l.size(); i++) chk("t4_order", 32'(got_at(i)), 32'(exp_l[i]));

    // Overflow wraps.
    got_q.delete();
    send(8'd127, 8'd1, 2'b00);
    idle();
    repeat (3) step();
    chk("t5_wrap", 32'(got_at(0)), 32'(8'h80));

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i), 8'd7, 2'b00);
    idle();
    chk("t6_pre_count", 32'(count), 32'd3);
    chk("t6_pre_ov", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_ov", 32'(out_valid), 32'd0);
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_in_ready", 32'(in_ready), 32'd1);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    got_q.delete();
    step();
    send(8'd3, 8'd4, 2'b01);
    idle();
    repeat (3) step();
    chk("t6_after_n", 32'(got_q.size()), 32'd1);
    chk("t6_after_res", 32'(got_at(0)), 32'(8'hFF));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_opcode = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    out_ready = 1'b1;
    repeat (8) step();
    chk("final_count", 32'(count), 32'd0);
    chk("final_ov", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
